// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: memory-stage state and writeback-select encodings.
// Opcodes for LL/SC are only consumed when MEM_WB_LLSC_EN is defined.
package cpu_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } mem_state_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PCP4 = 2'd2;
  localparam logic [1:0] WB_LUI  = 2'd3;

  localparam logic [5:0] OP_LL = 6'h30;
  localparam logic [5:0] OP_SC = 6'h38;

endpackage

// File: rtl/mem_wb_stage_wb_select.sv
// Writeback data mux, shared between the MEM/WB latch and forwarding logic.
module wb_select
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [1:0]        memToReg,
  input  logic [WORD_W-1:0] aluRes,
  input  logic [WORD_W-1:0] loadData,
  input  logic [WORD_W-1:0] pcp4,
  input  logic [WORD_W-1:0] luiValue,
  output logic [WORD_W-1:0] wdat
);

  always_comb begin
    wdat = aluRes;
    case (memToReg)
      WB_ALU:  wdat = aluRes;
      WB_LOAD: wdat = loadData;
      WB_PCP4: wdat = pcp4;
      WB_LUI:  wdat = luiValue;
      default: wdat = aluRes;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB latch: dcache request/hold, load capture, sticky halt.
// Optional LL/SC link tracking is enabled by defining MEM_WB_LLSC_EN.
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dREN_mem,
  input  logic              dWEN_mem,
  input  logic [WORD_W-1:0] portO_mem,
  input  logic [WORD_W-1:0] dmemstore_mem,
  input  logic              regWr_mem,
  input  logic [1:0]        MemToReg_mem,
  input  logic [WORD_W-1:0] luiValue_mem,
  input  logic [WORD_W-1:0] pcp4_mem,
  input  logic [SEL_W-1:0]  wsel_mem,
  input  logic [5:0]        op_mem,
  input  logic              halt_mem,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              flush,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              regWr_wb,
  output logic [SEL_W-1:0]  wsel_wb,
  output logic [WORD_W-1:0] wdat_wb,
  output logic              halt_wb
);

  mem_state_t        state, stateNext;
  logic              storeReq, memop, advance, inIdle, wbLoad;
  logic [WORD_W-1:0] loadHold, loadData, selData, wbData;

  assign inIdle = (state == IDLE);
  assign wbLoad = advance & ~halt_wb;

`ifdef MEM_WB_LLSC_EN
  logic              linkValid, scOk, scFail, isLL, isSC;
  logic [WORD_W-1:0] linkAddr;

  assign isLL   = (op_mem == OP_LL);
  assign isSC   = (op_mem == OP_SC);
  assign scOk   = isSC & linkValid & (linkAddr == portO_mem);
  assign scFail = isSC & ~scOk;

  // A failed SC never reaches the cache, so it neither stalls nor writes.
  assign storeReq = dWEN_mem & ~scFail;
  assign wbData   = isSC ? {{(WORD_W-1){1'b0}}, scOk} : selData;

  // Link state changes only when the entry retires so it stays stable
  // for the whole lifetime of an outstanding SC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      linkValid <= 1'b0;
      linkAddr  <= '0;
    end else if (wbLoad) begin
      if (isLL) begin
        linkValid <= 1'b1;
        linkAddr  <= portO_mem;
      end else if (dWEN_mem && (portO_mem == linkAddr)) begin
        linkValid <= 1'b0;
      end
    end
  end
`else
  logic unusedOp;
  assign unusedOp = ^op_mem;
  assign storeReq = dWEN_mem;
  assign wbData   = selData;
`endif

  assign memop = dREN_mem | storeReq;

  // Requests drop while reset is held so an in-flight access is abandoned at once.
  assign dmemREN   = dREN_mem & inIdle & ~halt_wb & ~RST;
  assign dmemWEN   = storeReq & inIdle & ~halt_wb & ~RST;
  assign dmemaddr  = portO_mem;
  assign dmemstore = dmemstore_mem;

  assign mem_stall = memop & inIdle & ~dhit;
  assign advance   = ihit & ~mem_stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (advance)                    stateNext = IDLE;
    else if (inIdle && memop && dhit) stateNext = DONE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          loadHold <= '0;
    else if (inIdle && memop && dhit) loadHold <= dmemload;
  end

  // Same-cycle dhit+ihit takes the data straight from the cache.
  assign loadData = (state == DONE) ? loadHold : dmemload;

  wb_select #(.WORD_W(WORD_W)) uSel (
    .memToReg (MemToReg_mem),
    .aluRes   (portO_mem),
    .loadData (loadData),
    .pcp4     (pcp4_mem),
    .luiValue (luiValue_mem),
    .wdat     (selData)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regWr_wb <= 1'b0;
      wsel_wb  <= '0;
      wdat_wb  <= '0;
      halt_wb  <= 1'b0;
    end else if (wbLoad) begin
      regWr_wb <= regWr_mem & ~flush;
      wsel_wb  <= wsel_mem;
      wdat_wb  <= wbData;
      if (!flush) halt_wb <= halt_mem;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage: per-cycle request/stall checks
// plus a queue of expected WB latch contents popped by an independent monitor.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dREN_mem, dWEN_mem, regWr_mem, halt_mem, ihit, dhit, flush;
  logic [31:0] portO_mem, dmemstore_mem, luiValue_mem, pcp4_mem, dmemload;
  logic [1:0]  MemToReg_mem;
  logic [4:0]  wsel_mem;
  logic [5:0]  op_mem;
  logic        dmemREN, dmemWEN, mem_stall, regWr_wb, halt_wb;
  logic [31:0] dmemaddr, dmemstore, wdat_wb;
  logic [4:0]  wsel_wb;

  mem_wb_stage dut (
    .CLK(CLK), .RST(RST),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .portO_mem(portO_mem),
    .dmemstore_mem(dmemstore_mem), .regWr_mem(regWr_mem), .MemToReg_mem(MemToReg_mem),
    .luiValue_mem(luiValue_mem), .pcp4_mem(pcp4_mem), .wsel_mem(wsel_mem),
    .op_mem(op_mem), .halt_mem(halt_mem), .ihit(ihit), .dhit(dhit),
    .dmemload(dmemload), .flush(flush),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .regWr_wb(regWr_wb), .wsel_wb(wsel_wb),
    .wdat_wb(wdat_wb), .halt_wb(halt_wb)
  );

  always #5 CLK = ~CLK;

  // kind: 0 ALU, 1 LW, 2 SW, 3 JAL, 4 LUI
  typedef struct {
    int          kind;
    logic [31:0] alu, st, lui, pc;
    logic [4:0]  wsel;
    logic        regWr, flush, halt;
    int          dh;
    logic [7:0]  mask;
  } txn_t;

  typedef struct {
    logic        regWr;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        halt;
    logic        dc;   // wsel/wdat are don't-care after a bubble
  } wb_t;

  wb_t mdl;
  wb_t expQ[$];
  wb_t monE;
  int  nChecks = 0;
  int  nFail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk("regWr_wb", {31'b0, regWr_wb}, {31'b0, monE.regWr});
      chk("halt_wb", {31'b0, halt_wb}, {31'b0, monE.halt});
      if (!monE.dc) begin
        chk("wsel_wb", {27'b0, wsel_wb}, {27'b0, monE.wsel});
        chk("wdat_wb", wdat_wb, monE.wdat);
      end
    end
  end

  task automatic runTxn(input txn_t t);
    logic        rd, wr, memop, done, adv, dhitV, ihitV, stallE;
    logic [31:0] loadV;
    logic [31:0] vals[4];
    int          m, c;
    rd    = (t.kind == 1);
    wr    = (t.kind == 2);
    memop = rd | wr;
    m     = (t.kind == 1) ? 1 : (t.kind == 3) ? 2 : (t.kind == 4) ? 3 : 0;
    dREN_mem = rd; dWEN_mem = wr;
    portO_mem = t.alu; dmemstore_mem = t.st; luiValue_mem = t.lui; pcp4_mem = t.pc;
    regWr_mem = t.regWr && !wr; MemToReg_mem = 2'(m); wsel_mem = t.wsel;
    op_mem = rd ? 6'h23 : wr ? 6'h2b : 6'h00;
    halt_mem = t.halt; flush = t.flush;
    done = 1'b0; adv = 1'b0; c = 0; loadV = '0;
    while (!adv) begin
      dhitV = memop && !done && (c == t.dh);
      ihitV = (c >= 8) ? 1'b1 : t.mask[c];
      dhit = dhitV; ihit = ihitV; dmemload = $urandom;
      @(negedge CLK);
      stallE = memop && !done && !dhitV;
      chk("mem_stall", {31'b0, mem_stall}, {31'b0, stallE});
      chk("dmemREN", {31'b0, dmemREN}, {31'b0, rd && !done && !mdl.halt});
      chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, wr && !done && !mdl.halt});
      chk("dmemaddr", dmemaddr, t.alu);
      chk("dmemstore", dmemstore, t.st);
      if (dhitV) loadV = dmemload;
      adv = ihitV && !stallE;
      if (adv) begin
        if (!mdl.halt) begin
          if (t.flush) begin
            mdl.regWr = 1'b0;
            mdl.dc    = 1'b1;
          end else begin
            vals[0] = t.alu; vals[1] = loadV; vals[2] = t.pc; vals[3] = t.lui;
            mdl.regWr = t.regWr && !wr;
            mdl.wsel  = t.wsel;
            mdl.wdat  = vals[m];
            mdl.halt  = t.halt;
            mdl.dc    = 1'b0;
          end
        end
      end else if (dhitV) begin
        done = 1'b1;
      end
      expQ.push_back(mdl);
      @(posedge CLK); #2;
      c++;
    end
    ihit = 1'b0; dhit = 1'b0;
  endtask

  function automatic txn_t mk(input int kind, input logic [31:0] alu, input logic [4:0] wsel,
                              input int dh, input logic [7:0] mask);
    txn_t t;
    t.kind = kind; t.alu = alu; t.st = $urandom; t.lui = $urandom; t.pc = $urandom;
    t.wsel = wsel; t.regWr = 1'b1; t.flush = 1'b0; t.halt = 1'b0; t.dh = dh; t.mask = mask;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    t = mk($urandom_range(0, 4), $urandom, 5'($urandom), $urandom_range(0, 3), 8'($urandom));
    t.regWr = 1'($urandom);
    t.flush = ($urandom_range(0, 99) < 15);
    return t;
  endfunction

  initial begin
    txn_t t;
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    mdl = '{regWr: 1'b0, wsel: '0, wdat: '0, halt: 1'b0, dc: 1'b0};
    RST = 1'b1;
    dREN_mem = 1'b1; dWEN_mem = 1'b0; portO_mem = '0; dmemstore_mem = '0;
    regWr_mem = 1'b0; MemToReg_mem = '0; luiValue_mem = '0; pcp4_mem = '0;
    wsel_mem = '0; op_mem = '0; halt_mem = 1'b0; ihit = 1'b1; dhit = 1'b0;
    dmemload = '0; flush = 1'b0;
    #3;
    chk("rst dmemREN", {31'b0, dmemREN}, 32'd0);
    chk("rst regWr_wb", {31'b0, regWr_wb}, 32'd0);
    chk("rst wsel_wb", {27'b0, wsel_wb}, 32'd0);
    chk("rst wdat_wb", wdat_wb, 32'd0);
    chk("rst halt_wb", {31'b0, halt_wb}, 32'd0);
    dREN_mem = 1'b0;
    @(posedge CLK); @(posedge CLK); #2;
    RST = 1'b0;

    // Directed: LW with late dhit, SW held in DONE, jal, flushed ADD
    runTxn(mk(1, 32'h100, 5'd5, 3, 8'hFF));
    t = mk(2, 32'h200, 5'd0, 1, 8'b0001_0000); t.regWr = 1'b0;
    runTxn(t);
    t = mk(3, 32'h0, 5'd31, 0, 8'hFF); t.pc = 32'h44;
    runTxn(t);
    t = mk(0, 32'h1234, 5'd7, 0, 8'hFF); t.flush = 1'b1;
    runTxn(t);

    for (int i = 0; i < 300; i++) runTxn(rnd());

    // Halt then attempt more work: requests suppressed, WB frozen
    t = mk(0, 32'h55, 5'd3, 0, 8'hFF); t.halt = 1'b1;
    runTxn(t);
    runTxn(mk(1, 32'h300, 5'd9, 2, 8'hFF));
    runTxn(mk(3, 32'h0, 5'd31, 0, 8'hFF));

    // Clear halt, then reset in the middle of an outstanding LW
    RST = 1'b1; #2; RST = 1'b0;
    mdl = '{regWr: 1'b0, wsel: '0, wdat: '0, halt: 1'b0, dc: 1'b0};
    dREN_mem = 1'b1; dWEN_mem = 1'b0; portO_mem = 32'h400; MemToReg_mem = 2'd1;
    regWr_mem = 1'b1; wsel_mem = 5'd6; halt_mem = 1'b0; flush = 1'b0;
    ihit = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("pre-rst mem_stall", {31'b0, mem_stall}, 32'd1);
      chk("pre-rst dmemREN", {31'b0, dmemREN}, 32'd1);
      expQ.push_back(mdl);
      @(posedge CLK); #2;
    end
    @(negedge CLK); #3;
    RST = 1'b1; #1;
    chk("mid-rst dmemREN", {31'b0, dmemREN}, 32'd0);
    chk("mid-rst regWr_wb", {31'b0, regWr_wb}, 32'd0);
    chk("mid-rst wsel_wb", {27'b0, wsel_wb}, 32'd0);
    chk("mid-rst wdat_wb", wdat_wb, 32'd0);
    chk("mid-rst halt_wb", {31'b0, halt_wb}, 32'd0);
    @(posedge CLK); @(posedge CLK); #2;
    RST = 1'b0;
    runTxn(mk(1, 32'h400, 5'd6, 1, 8'hFF));

    for (int i = 0; i < 50; i++) runTxn(rnd());

    @(posedge CLK); #3;
    if (expQ.size() != 0) begin
      nChecks++; nFail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
